// File: rtl/pmod_enc_if.sv
`default_nettype none
// ============================================================================
// Module      : pmod_enc_if
// Description : PmodENC pin conditioner. Synchronizes and debounces the raw
//               quadrature A/B, push-button and slide-switch pins, decodes
//               full quadrature detents into a signed wrapping rotation count,
//               and keeps sticky button-press and quadrature-error flags for
//               the AXI4-Lite register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module pmod_enc_if #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 enc_btn,
  input  logic                 enc_sw,
  input  logic                 cnt_clr,
  input  logic                 flag_clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 btn_level,
  output logic                 sw_level,
  output logic                 btn_event,
  output logic                 quad_err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int                 DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]    DB_ONE  = DB_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Channel order inside the conditioned vectors: {sw, btn, b, a}.
  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_BTN = 2;
  localparam int CH_SW  = 3;
  localparam int N_CH   = 4;

  // A and B idle high (detent rest), button and switch idle low.
  localparam logic [N_CH-1:0] DEB_RST = 4'b0011;

  // --------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer + stable-count debouncer per pin
  // --------------------------------------------------------------------------
  logic [N_CH-1:0] w_raw;
  logic [N_CH-1:0] w_deb;

  assign w_raw = {enc_sw, enc_btn, enc_b, enc_a};

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    logic            r_meta;
    logic            r_sync;
    logic            r_deb;
    logic [DB_W-1:0] r_dbcnt;

    // Synchronize the raw pin and accept a new level only after it has
    // differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        r_meta  <= 1'b0;
        r_sync  <= 1'b0;
        r_deb   <= DEB_RST[gi];
        r_dbcnt <= '0;
      end else begin
        r_meta <= w_raw[gi];
        r_sync <= r_meta;
        if (r_sync == r_deb) begin
          r_dbcnt <= '0;
        end else if (r_dbcnt == DB_LAST) begin
          r_deb   <= r_sync;
          r_dbcnt <= '0;
        end else begin
          r_dbcnt <= r_dbcnt + DB_ONE;
        end
      end
    end

    assign w_deb[gi] = r_deb;
  end

  // --------------------------------------------------------------------------
  // Quadrature decoder
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_REST = 3'd0,
    ST_CW1  = 3'd1,
    ST_CW2  = 3'd2,
    ST_CW3  = 3'd3,
    ST_CCW1 = 3'd4,
    ST_CCW2 = 3'd5,
    ST_CCW3 = 3'd6,
    ST_ERR  = 3'd7
  } quad_state_t;

  quad_state_t r_state;
  quad_state_t w_next;
  logic [1:0]  w_ab;
  logic        w_inc;
  logic        w_dec;
  logic        w_err_set;

  // Debounced pins as {A,B}, so "01" means A low and B high.
  assign w_ab = {w_deb[CH_A], w_deb[CH_B]};

  // Quadrature state register; reset abandons any partial detent.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= ST_REST;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a detent only counts on the return to rest from the
  // third step, and any two-bit jump lands in the error state.
  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
    w_dec  = 1'b0;
    unique case (r_state)
      ST_REST: begin
        case (w_ab)
          2'b01:   w_next = ST_CW1;
          2'b10:   w_next = ST_CCW1;
          2'b00:   w_next = ST_ERR;
          default: w_next = ST_REST;
        endcase
      end
      ST_CW1: begin
        case (w_ab)
          2'b00:   w_next = ST_CW2;
          2'b11:   w_next = ST_REST;
          2'b10:   w_next = ST_ERR;
          default: w_next = ST_CW1;
        endcase
      end
      ST_CW2: begin
        case (w_ab)
          2'b10:   w_next = ST_CW3;
          2'b01:   w_next = ST_CW1;
          2'b11:   w_next = ST_ERR;
          default: w_next = ST_CW2;
        endcase
      end
      ST_CW3: begin
        case (w_ab)
          2'b11: begin
            w_next = ST_REST;
            w_inc  = 1'b1;
          end
          2'b00:   w_next = ST_CW2;
          2'b01:   w_next = ST_ERR;
          default: w_next = ST_CW3;
        endcase
      end
      ST_CCW1: begin
        case (w_ab)
          2'b00:   w_next = ST_CCW2;
          2'b11:   w_next = ST_REST;
          2'b01:   w_next = ST_ERR;
          default: w_next = ST_CCW1;
        endcase
      end
      ST_CCW2: begin
        case (w_ab)
          2'b01:   w_next = ST_CCW3;
          2'b10:   w_next = ST_CCW1;
          2'b11:   w_next = ST_ERR;
          default: w_next = ST_CCW2;
        endcase
      end
      ST_CCW3: begin
        case (w_ab)
          2'b11: begin
            w_next = ST_REST;
            w_dec  = 1'b1;
          end
          2'b00:   w_next = ST_CCW2;
          2'b10:   w_next = ST_ERR;
          default: w_next = ST_CCW3;
        endcase
      end
      ST_ERR: begin
        if (w_ab == 2'b11) begin
          w_next = ST_REST;
        end
      end
      default: w_next = ST_REST;
    endcase
  end

  // The error flag is raised on entry into the error state only.
  assign w_err_set = (w_next == ST_ERR) && (r_state != ST_ERR);

  // --------------------------------------------------------------------------
  // Rotation counter
  // --------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] r_count;

  // Wrapping up/down count; a clear strobe overrides a same-cycle detent.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_count <= '0;
    end else if (cnt_clr) begin
      r_count <= '0;
    end else if (w_inc) begin
      r_count <= r_count + CNT_ONE;
    end else if (w_dec) begin
      r_count <= r_count - CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky flags
  // --------------------------------------------------------------------------
  logic r_btn_prev;
  logic r_btn_event;
  logic r_quad_err;
  logic w_btn_rise;

  assign w_btn_rise = w_deb[CH_BTN] & ~r_btn_prev;

  // Remember the previous debounced button level for rising-edge detection.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_prev <= w_deb[CH_BTN];
    end
  end

  // Sticky press flag; a new press beats a same-cycle clear.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_btn_event <= 1'b0;
    end else if (w_btn_rise) begin
      r_btn_event <= 1'b1;
    end else if (flag_clr) begin
      r_btn_event <= 1'b0;
    end
  end

  // Sticky quadrature-error flag; a new error beats a same-cycle clear.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_quad_err <= 1'b0;
    end else if (w_err_set) begin
      r_quad_err <= 1'b1;
    end else if (flag_clr) begin
      r_quad_err <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign count     = r_count;
  assign btn_level = w_deb[CH_BTN];
  assign sw_level  = w_deb[CH_SW];
  assign btn_event = r_btn_event;
  assign quad_err  = r_quad_err;

endmodule
`default_nettype wire

// File: tb/tb_pmod_enc_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmod_enc_if
// Description : Directed self-checking bench for pmod_enc_if with a small
//               output model and an expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmod_enc_if;

  localparam int DEB = 4;
  localparam int CW  = 16;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          enc_a;
  logic          enc_b;
  logic          enc_btn;
  logic          enc_sw;
  logic          cnt_clr;
  logic          flag_clr;
  logic [CW-1:0] count;
  logic          btn_level;
  logic          sw_level;
  logic          btn_event;
  logic          quad_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string         tag;
    logic [CW-1:0] cnt;
    logic          bl;
    logic          sl;
    logic          be;
    logic          qe;
  } exp_t;

  exp_t sb[$];

  // Model of the expected outputs, updated by the directed steps.
  logic [CW-1:0] m_cnt;
  logic          m_bl;
  logic          m_sl;
  logic          m_be;
  logic          m_qe;

  pmod_enc_if #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (CW)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .enc_btn  (enc_btn),
    .enc_sw   (enc_sw),
    .cnt_clr  (cnt_clr),
    .flag_clr (flag_clr),
    .count    (count),
    .btn_level(btn_level),
    .sw_level (sw_level),
    .btn_event(btn_event),
    .quad_err (quad_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic idle(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.cnt = m_cnt;
    e.bl  = m_bl;
    e.sl  = m_sl;
    e.be  = m_be;
    e.qe  = m_qe;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string field,
                     input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, got, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "count",     count,            e.cnt);
      cmp(e.tag, "btn_level", CW'(btn_level),   CW'(e.bl));
      cmp(e.tag, "sw_level",  CW'(sw_level),    CW'(e.sl));
      cmp(e.tag, "btn_event", CW'(btn_event),   CW'(e.be));
      cmp(e.tag, "quad_err",  CW'(quad_err),    CW'(e.qe));
    end
  endtask

  task automatic set_ab(input logic a, input logic b, input int hold);
    enc_a = a;
    enc_b = b;
    idle(hold);
  endtask

  // One full detent; the count must land exactly 2+DEB+1 cycles after the
  // final raw edge to 11. Optionally strobe cnt_clr on the landing cycle.
  task automatic detent(input bit cw, input bit clr_on_land, input string tag);
    if (cw) begin
      set_ab(1'b0, 1'b1, 10);
      set_ab(1'b0, 1'b0, 10);
      set_ab(1'b1, 1'b0, 10);
    end else begin
      set_ab(1'b1, 1'b0, 10);
      set_ab(1'b0, 1'b0, 10);
      set_ab(1'b0, 1'b1, 10);
    end
    enc_a = 1'b1;
    enc_b = 1'b1;
    idle(2 + DEB);
    push_exp({tag, "_before"});
    check_out();
    if (clr_on_land) cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    if (clr_on_land)  m_cnt = '0;
    else if (cw)      m_cnt = m_cnt + 16'd1;
    else              m_cnt = m_cnt - 16'd1;
    push_exp({tag, "_land"});
    check_out();
    idle(4);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESET   = 1'b1;
    enc_a    = 1'b1;
    enc_b    = 1'b1;
    enc_btn  = 1'b0;
    enc_sw   = 1'b0;
    cnt_clr  = 1'b0;
    flag_clr = 1'b0;
    m_cnt = '0; m_bl = 1'b0; m_sl = 1'b0; m_be = 1'b0; m_qe = 1'b0;

    // Reset state
    idle(2);
    push_exp("reset");
    check_out();
    ARESET = 1'b0;
    idle(10);
    push_exp("idle");
    check_out();

    // Reset in the middle of a CW sequence; finish with 10 -> 11, which only
    // counts if the partial detent survived the reset.
    set_ab(1'b0, 1'b1, 10);
    set_ab(1'b0, 1'b0, 10);
    ARESET = 1'b1;
    enc_a  = 1'b1;
    enc_b  = 1'b0;
    idle(2);
    ARESET = 1'b0;
    push_exp("midreset");
    check_out();
    idle(12);
    set_ab(1'b1, 1'b1, 12);
    push_exp("midreset_after");
    check_out();

    // Single CW then single CCW detent
    detent(1'b1, 1'b0, "cw1");
    detent(1'b0, 1'b0, "ccw1");

    // Backtrack without completing a detent
    set_ab(1'b0, 1'b1, 10);
    set_ab(1'b0, 1'b0, 10);
    set_ab(1'b0, 1'b1, 10);
    set_ab(1'b1, 1'b1, 10);
    push_exp("backtrack");
    check_out();

    // 3-cycle glitch on A is ignored
    enc_a = 1'b0;
    idle(3);
    enc_a = 1'b1;
    idle(10);
    push_exp("glitch");
    check_out();

    // Illegal jump 11 -> 00
    enc_a = 1'b0;
    enc_b = 1'b0;
    idle(2 + DEB);
    push_exp("jump_before");
    check_out();
    idle(1);
    m_qe = 1'b1;
    push_exp("jump_err");
    check_out();
    idle(5);
    set_ab(1'b1, 1'b1, 10);
    push_exp("err_rest");
    check_out();
    flag_clr = 1'b1;
    idle(1);
    flag_clr = 1'b0;
    m_qe = 1'b0;
    push_exp("err_clr");
    check_out();

    // Preload 0x7FFF, then wrap to 0x8000
    force dut.r_count = 16'h7FFF;
    idle(1);
    release dut.r_count;
    m_cnt = 16'h7FFF;
    idle(1);
    push_exp("preload");
    check_out();
    detent(1'b1, 1'b0, "wrap_pos");
    detent(1'b1, 1'b1, "clr_vs_inc");
    detent(1'b0, 1'b0, "wrap_neg");
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    m_cnt = '0;
    push_exp("cnt_clr");
    check_out();

    // Button press: level after 2+DEB cycles, event one cycle later
    enc_btn = 1'b1;
    idle(2 + DEB);
    m_bl = 1'b1;
    push_exp("btn_level");
    check_out();
    idle(1);
    m_be = 1'b1;
    push_exp("btn_event");
    check_out();
    idle(3);
    enc_btn = 1'b0;
    idle(10);
    m_bl = 1'b0;
    push_exp("btn_release");
    check_out();

    // New press edge coinciding with flag_clr: set wins
    enc_btn = 1'b1;
    idle(2 + DEB);
    flag_clr = 1'b1;
    idle(1);
    flag_clr = 1'b0;
    m_bl = 1'b1;
    push_exp("btn_set_wins");
    check_out();
    flag_clr = 1'b1;
    idle(1);
    flag_clr = 1'b0;
    m_be = 1'b0;
    push_exp("btn_clr");
    check_out();
    enc_btn = 1'b0;
    idle(10);
    m_bl = 1'b0;
    push_exp("btn_release2");
    check_out();

    // Switch follows after 2+DEB cycles
    enc_sw = 1'b1;
    idle(1 + DEB);
    push_exp("sw_before");
    check_out();
    idle(1);
    m_sl = 1'b1;
    push_exp("sw_level");
    check_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
